// File: rtl/tlb_sync_if.sv
// tlb_sync_if: search, write, read and Random-control signals between the TLB and its clients
interface tlb_sync_if #(
    parameter int TLBNUM = 16,
    parameter int ASIDW = 8,
    parameter int PFNW = 20,
    parameter int IDXW = $clog2(TLBNUM)
);
    logic s0_req, s0_odd_page, s0_rsp_valid, s0_found, s0_multi, s0_d, s0_v;
    logic [18:0] s0_vpn2;
    logic [ASIDW-1:0] s0_asid;
    logic [IDXW-1:0] s0_index;
    logic [PFNW-1:0] s0_pfn;
    logic [2:0] s0_c;
    logic s1_req, s1_odd_page, s1_rsp_valid, s1_found, s1_multi, s1_d, s1_v;
    logic [18:0] s1_vpn2;
    logic [ASIDW-1:0] s1_asid;
    logic [IDXW-1:0] s1_index;
    logic [PFNW-1:0] s1_pfn;
    logic [2:0] s1_c;
    logic we, w_random, w_g, w_d0, w_v0, w_d1, w_v1;
    logic [IDXW-1:0] w_index;
    logic [18:0] w_vpn2;
    logic [ASIDW-1:0] w_asid;
    logic [PFNW-1:0] w_pfn0, w_pfn1;
    logic [2:0] w_c0, w_c1;
    logic [IDXW-1:0] r_index;
    logic [18:0] r_vpn2;
    logic [ASIDW-1:0] r_asid;
    logic r_g, r_d0, r_v0, r_d1, r_v1;
    logic [PFNW-1:0] r_pfn0, r_pfn1;
    logic [2:0] r_c0, r_c1;
    logic flush, wired_we;
    logic [IDXW-1:0] wired, random_index;

    modport master (
        output s0_req, s0_vpn2, s0_odd_page, s0_asid,
        input  s0_rsp_valid, s0_found, s0_multi, s0_index, s0_pfn, s0_c, s0_d, s0_v,
        output s1_req, s1_vpn2, s1_odd_page, s1_asid,
        input  s1_rsp_valid, s1_found, s1_multi, s1_index, s1_pfn, s1_c, s1_d, s1_v,
        output we, w_random, w_index, w_vpn2, w_asid, w_g,
        output w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
        output r_index,
        input  r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1,
        output flush, wired, wired_we,
        input  random_index
    );

    modport slave (
        input  s0_req, s0_vpn2, s0_odd_page, s0_asid,
        output s0_rsp_valid, s0_found, s0_multi, s0_index, s0_pfn, s0_c, s0_d, s0_v,
        input  s1_req, s1_vpn2, s1_odd_page, s1_asid,
        output s1_rsp_valid, s1_found, s1_multi, s1_index, s1_pfn, s1_c, s1_d, s1_v,
        input  we, w_random, w_index, w_vpn2, w_asid, w_g,
        input  w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
        input  r_index,
        output r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1,
        input  flush, wired, wired_we,
        output random_index
    );
endinterface

// File: rtl/tlb_sync.sv
// tlb_sync: N-entry fully associative MIPS TLB with two registered search ports, a registered read port and a Random counter
module tlb_sync #(
    parameter int TLBNUM = 16,
    parameter int IDXW = $clog2(TLBNUM),
    parameter int ASIDW = 8,
    parameter int PFNW = 20
) (
    input logic clk,
    input logic reset,
    tlb_sync_if.slave bus
);
    typedef struct packed {
        logic [18:0] vpn2;
        logic [ASIDW-1:0] asid;
        logic g;
        logic [PFNW-1:0] pfn0;
        logic [2:0] c0;
        logic d0, v0;
        logic [PFNW-1:0] pfn1;
        logic [2:0] c1;
        logic d1, v1;
    } ent_t;

    typedef struct packed {
        logic found, multi;
        logic [IDXW-1:0] index;
        logic [PFNW-1:0] pfn;
        logic [2:0] c;
        logic d, v;
    } res_t;

    ent_t tab [TLBNUM];
    ent_t rd;
    logic [TLBNUM-1:0] e;
    res_t res0, res1;
    logic rv0, rv1;
    logic [IDXW-1:0] rnd, wi;

    // Scanning from the top down lets the lowest matching entry overwrite the selected fields last
    function automatic res_t lookup(input logic [18:0] vpn2, input logic odd, input logic [ASIDW-1:0] asid);
        res_t r;
        int n;
        r = '0;
        n = 0;
        for (int i = TLBNUM - 1; i >= 0; i--)
            if (e[i] && tab[i].vpn2 == vpn2 && (tab[i].g || tab[i].asid == asid)) begin
                n++;
                r.index = IDXW'(i);
                r.pfn = odd ? tab[i].pfn1 : tab[i].pfn0;
                r.c = odd ? tab[i].c1 : tab[i].c0;
                r.d = odd ? tab[i].d1 : tab[i].d0;
                r.v = odd ? tab[i].v1 : tab[i].v0;
            end
        r.found = n > 0;
        r.multi = n > 1;
        return r;
    endfunction

    assign wi = bus.w_random ? rnd : bus.w_index;

    // Tag/data storage is not reset; a write coinciding with reset is dropped
    always_ff @(posedge clk)
        if (!reset && bus.we)
            tab[wi] <= {bus.w_vpn2, bus.w_asid, bus.w_g, bus.w_pfn0, bus.w_c0, bus.w_d0, bus.w_v0,
                        bus.w_pfn1, bus.w_c1, bus.w_d1, bus.w_v1};

    // Entry-valid bits: flush clears all, then a same-cycle write re-validates its target
    always_ff @(posedge clk)
        if (reset)
            e <= '0;
        else begin
            if (bus.flush)
                e <= '0;
            if (bus.we)
                e[wi] <= 1'b1;
        end

    // Search results sample the pre-edge table and are held while no request is present
    always_ff @(posedge clk)
        if (reset) begin
            rv0 <= 1'b0;
            rv1 <= 1'b0;
            res0 <= '0;
            res1 <= '0;
        end else begin
            rv0 <= bus.s0_req;
            rv1 <= bus.s1_req;
            if (bus.s0_req)
                res0 <= lookup(bus.s0_vpn2, bus.s0_odd_page, bus.s0_asid);
            if (bus.s1_req)
                res1 <= lookup(bus.s1_vpn2, bus.s1_odd_page, bus.s1_asid);
        end

    // Read port returns stored fields regardless of the entry-valid bit
    always_ff @(posedge clk)
        rd <= reset ? '0 : tab[bus.r_index];

    // Random counts down to Wired, then wraps to the top; a Wired write restarts it
    always_ff @(posedge clk)
        rnd <= (reset || bus.wired_we || rnd <= bus.wired) ? IDXW'(TLBNUM - 1) : rnd - 1'b1;

    assign bus.s0_rsp_valid = rv0;
    assign bus.s0_found = res0.found;
    assign bus.s0_multi = res0.multi;
    assign bus.s0_index = res0.index;
    assign bus.s0_pfn = res0.pfn;
    assign bus.s0_c = res0.c;
    assign bus.s0_d = res0.d;
    assign bus.s0_v = res0.v;
    assign bus.s1_rsp_valid = rv1;
    assign bus.s1_found = res1.found;
    assign bus.s1_multi = res1.multi;
    assign bus.s1_index = res1.index;
    assign bus.s1_pfn = res1.pfn;
    assign bus.s1_c = res1.c;
    assign bus.s1_d = res1.d;
    assign bus.s1_v = res1.v;
    assign bus.r_vpn2 = rd.vpn2;
    assign bus.r_asid = rd.asid;
    assign bus.r_g = rd.g;
    assign bus.r_pfn0 = rd.pfn0;
    assign bus.r_c0 = rd.c0;
    assign bus.r_d0 = rd.d0;
    assign bus.r_v0 = rd.v0;
    assign bus.r_pfn1 = rd.pfn1;
    assign bus.r_c1 = rd.c1;
    assign bus.r_d1 = rd.d1;
    assign bus.r_v1 = rd.v1;
    assign bus.random_index = rnd;
endmodule
